// File: rtl/glyph_pixel_streamer_if.sv
// Character-in / ROM / pixel-out bundle for the glyph pixel streamer.
// The streamer takes the slave view; the producer, ROM model and pixel sink take the master view.
interface glyph_pixel_streamer_if #(
    parameter int COLS    = 5,
    parameter int ROWS    = 7,
    parameter int COLOR_W = 24
);
    logic [6:0]           char_in;
    logic [COLOR_W-1:0]   fg_in;
    logic [COLOR_W-1:0]   bg_in;
    logic                 char_valid;
    logic                 char_ready;
    logic [6:0]           rom_addr;
    logic [ROWS*COLS-1:0] rom_data;
    logic                 pix_valid;
    logic                 pix_ready;
    logic [COLOR_W-1:0]   pix_color;
    logic                 pix_on;
    logic                 pix_last;

    modport slave (
        input  char_in, fg_in, bg_in, char_valid, rom_data, pix_ready,
        output char_ready, rom_addr, pix_valid, pix_color, pix_on, pix_last
    );

    modport master (
        output char_in, fg_in, bg_in, char_valid, rom_data, pix_ready,
        input  char_ready, rom_addr, pix_valid, pix_color, pix_on, pix_last
    );
endinterface

// File: rtl/glyph_pixel_streamer.sv
// Fetches one 5x7 glyph bitmap from the character ROM and streams it as one
// GRB colour per pixel, in LED-matrix order, to the WS2812B serializer.
module glyph_pixel_streamer #(
    parameter int COLS       = 5,
    parameter int ROWS       = 7,
    parameter int COLOR_W    = 24,
    parameter int SERPENTINE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    glyph_pixel_streamer_if.slave bus,
    output logic                 busy,
    output logic [1:0]           state_dbg
);
    localparam int NPIX = ROWS * COLS;
    localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int IW   = $clog2(NPIX + 1);

    // Handshakes: a transfer happens on a rising clk edge where valid && ready are
    // both high; the sender holds its payload stable until that edge, and the
    // receiver may drop or raise ready freely without any combinational path back.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        STREAM = 2'd2
    } state_t;

    state_t               state;
    logic [RW-1:0]        row;
    logic [CW-1:0]        col;
    logic [6:0]           char_q;
    logic [COLOR_W-1:0]   fg_q;
    logic [COLOR_W-1:0]   bg_q;
    logic [NPIX-1:0]      bitmap;

    logic                 char_ready_q;
    logic                 pix_valid_q;
    logic                 pix_on_q;
    logic                 pix_last_q;
    logic [COLOR_W-1:0]   pix_color_q;
    logic                 busy_q;

    logic [RW-1:0]        nxt_row;
    logic [CW-1:0]        nxt_col;
    logic                 nxt_on;
    logic                 nxt_last;
    logic                 first_on;

    // Bitmap bit shown at counter position (r, c); odd rows run right-to-left
    // when the matrix is wired as a zig-zag.
    function automatic logic pick(input logic [NPIX-1:0] bm,
                                  input logic [RW-1:0]   r,
                                  input logic [CW-1:0]   c);
        logic [CW-1:0] cp;
        logic [IW-1:0] k;
        cp = ((SERPENTINE != 0) && r[0]) ? (CW'(COLS - 1) - c) : c;
        k  = IW'(r) * IW'(COLS) + IW'(cp);
        return bm[IW'(NPIX - 1) - k];
    endfunction

    always_comb begin
        nxt_row = row;
        nxt_col = col + CW'(1);
        if (col == CW'(COLS - 1)) begin
            nxt_col = '0;
            nxt_row = row + RW'(1);
        end
        nxt_on   = pick(bitmap, nxt_row, nxt_col);
        nxt_last = (nxt_row == RW'(ROWS - 1)) && (nxt_col == CW'(COLS - 1));
        first_on = bus.rom_data[NPIX-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            row          <= '0;
            col          <= '0;
            char_q       <= '0;
            fg_q         <= '0;
            bg_q         <= '0;
            bitmap       <= '0;
            char_ready_q <= 1'b1;
            pix_valid_q  <= 1'b0;
            pix_on_q     <= 1'b0;
            pix_last_q   <= 1'b0;
            pix_color_q  <= '0;
            busy_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.char_valid) begin
                        char_q       <= bus.char_in;
                        fg_q         <= bus.fg_in;
                        bg_q         <= bus.bg_in;
                        char_ready_q <= 1'b0;
                        busy_q       <= 1'b1;
                        state        <= FETCH;
                    end
                end
                FETCH: begin
                    // ROM is combinational on char_q, so the bitmap is valid this cycle.
                    bitmap      <= bus.rom_data;
                    row         <= '0;
                    col         <= '0;
                    pix_valid_q <= 1'b1;
                    pix_on_q    <= first_on;
                    pix_color_q <= first_on ? fg_q : bg_q;
                    pix_last_q  <= (NPIX == 1);
                    state       <= STREAM;
                end
                STREAM: begin
                    if (bus.pix_ready) begin
                        if (pix_last_q) begin
                            pix_valid_q  <= 1'b0;
                            pix_on_q     <= 1'b0;
                            pix_last_q   <= 1'b0;
                            pix_color_q  <= '0;
                            char_ready_q <= 1'b1;
                            busy_q       <= 1'b0;
                            state        <= IDLE;
                        end else begin
                            row         <= nxt_row;
                            col         <= nxt_col;
                            pix_on_q    <= nxt_on;
                            pix_color_q <= nxt_on ? fg_q : bg_q;
                            pix_last_q  <= nxt_last;
                        end
                    end
                end
                default: begin
                    char_ready_q <= 1'b1;
                    pix_valid_q  <= 1'b0;
                    busy_q       <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

    assign bus.char_ready = char_ready_q;
    assign bus.rom_addr   = char_q;
    assign bus.pix_valid  = pix_valid_q;
    assign bus.pix_on     = pix_on_q;
    assign bus.pix_last   = pix_last_q;
    assign bus.pix_color  = pix_color_q;
    assign busy           = busy_q;
    assign state_dbg      = state;
endmodule

// File: tb/tb_glyph_pixel_streamer.sv
// Directed bench for glyph_pixel_streamer: vector table of glyphs with hand-derived
// emission masks, plus sequences for reset, linear wiring, back-to-back and mid-glyph reset.
module tb_glyph_pixel_streamer;
    localparam int COLS    = 5;
    localparam int ROWS    = 7;
    localparam int COLOR_W = 24;
    localparam int NPIX    = 35;
    localparam int SB_W    = COLOR_W + 2;

    typedef struct {
        logic [6:0]      ch;
        logic [23:0]     fg;
        logic [23:0]     bg;
        logic [NPIX-1:0] bm;
        logic [NPIX-1:0] emit;
    } vec_t;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    glyph_pixel_streamer_if #(.COLS(COLS), .ROWS(ROWS), .COLOR_W(COLOR_W)) gif ();
    glyph_pixel_streamer_if #(.COLS(COLS), .ROWS(ROWS), .COLOR_W(COLOR_W)) lif ();

    logic       busy;
    logic       lbusy;
    logic [1:0] state_dbg;
    logic [1:0] lstate_dbg;

    glyph_pixel_streamer #(.COLS(COLS), .ROWS(ROWS), .COLOR_W(COLOR_W), .SERPENTINE(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (gif),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    glyph_pixel_streamer #(.COLS(COLS), .ROWS(ROWS), .COLOR_W(COLOR_W), .SERPENTINE(0)) dut_lin (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (lif),
        .busy      (lbusy),
        .state_dbg (lstate_dbg)
    );

    // character ROM models
    logic [6:0]      cur_char = 7'h00;
    logic [NPIX-1:0] cur_bm   = '0;

    always_comb begin
        gif.rom_data = '0;
        if (gif.rom_addr == cur_char)   gif.rom_data = cur_bm;
        else if (gif.rom_addr == 7'h48) gif.rom_data = 35'h1_2345_6789;
        else if (gif.rom_addr == 7'h49) gif.rom_data = 35'h6_5432_1ABC;
    end

    always_comb begin
        lif.rom_data = '0;
        if (lif.rom_addr == 7'h42) lif.rom_data = 35'h0_2000_0000;
    end

    // scoreboard
    logic [SB_W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    vec_t vecs[7];

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // driver: one glyph through the serpentine DUT, optional random backpressure
    task automatic run_glyph(input vec_t v, input bit rand_ready);
        int              idx;
        int              guard;
        bit              stalled;
        logic [SB_W-1:0] held;
        logic [SB_W-1:0] act;
        logic [SB_W-1:0] expv;
        logic [NPIX-1:0] sh;
        logic            on;
        exp_q.delete();
        for (int k = 0; k < NPIX; k++) begin
            sh = v.emit >> (NPIX - 1 - k);
            on = sh[0];
            exp_q.push_back({(k == NPIX - 1) ? 1'b1 : 1'b0, on, on ? v.fg : v.bg});
        end
        cur_char       = v.ch;
        cur_bm         = v.bm;
        gif.char_in    = v.ch;
        gif.fg_in      = v.fg;
        gif.bg_in      = v.bg;
        gif.char_valid = 1'b1;
        gif.pix_ready  = 1'b0;
        check("char_ready_idle", gif.char_ready, 1);
        tick();
        gif.char_valid = 1'b0;
        check("busy_fetch", busy, 1);
        check("char_ready_fetch", gif.char_ready, 0);
        check("pix_valid_fetch", gif.pix_valid, 0);
        check("rom_addr_fetch", gif.rom_addr, v.ch);
        check("state_fetch", state_dbg, 1);
        tick();
        idx = 0;
        guard = 0;
        stalled = 0;
        held = '0;
        while (idx < NPIX && guard < 400) begin
            act = {gif.pix_last, gif.pix_on, gif.pix_color};
            check("pix_valid_stream", gif.pix_valid, 1);
            if (stalled) check("stall_stable", act, held);
            gif.pix_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (gif.pix_ready && exp_q.size() > 0) begin
                expv = exp_q.pop_front();
                check($sformatf("pixel%0d_ch%0h", idx, v.ch), act, expv);
                idx++;
                stalled = 0;
            end else begin
                held = act;
                stalled = 1;
            end
            tick();
            guard++;
        end
        check("handshakes", idx, NPIX);
        gif.pix_ready = 1'b0;
        check("pix_valid_after_last", gif.pix_valid, 0);
        check("char_ready_after_last", gif.char_ready, 1);
        check("busy_after_last", busy, 0);
        check("state_after_last", state_dbg, 0);
    endtask

    initial begin
        int guard;
        int n;
        int t1;
        int t2;
        int idx;
        int first_idx;
        int ones;

        //                 ch     fg          bg          bitmap           emitted order
        vecs[0] = '{7'h41, 24'hFF0000, 24'h000000, 35'h4_0000_0000, 35'h4_0000_0000};
        vecs[1] = '{7'h42, 24'h00FF00, 24'h000010, 35'h0_2000_0000, 35'h0_0200_0000};
        vecs[2] = '{7'h44, 24'h0000FF, 24'h101010, 35'h0_3100_0000, 35'h0_0700_0000};
        vecs[3] = '{7'h45, 24'h123456, 24'hABCDEF, 35'h0_0000_0021, 35'h0_0000_0201};
        vecs[4] = '{7'h01, 24'hFFFFFF, 24'h000001, 35'h7_FFFF_FFFF, 35'h7_FFFF_FFFF};
        vecs[5] = '{7'h7F, 24'h0A0B0C, 24'h0C0B0A, 35'h7_FFFF_FFFF, 35'h7_FFFF_FFFF};
        vecs[6] = '{7'h46, 24'h00AA55, 24'h550000, 35'h7_C200_0000, 35'h7_E000_0000};

        gif.char_in = 7'h41;  gif.fg_in = 24'h0; gif.bg_in = 24'h0;
        gif.char_valid = 1'b1; gif.pix_ready = 1'b0;
        lif.char_in = 7'h00;  lif.fg_in = 24'h0; lif.bg_in = 24'h0;
        lif.char_valid = 1'b0; lif.pix_ready = 1'b0;

        // reset held with char_valid high
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_char_ready", gif.char_ready, 1);
        check("rst_pix_valid", gif.pix_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_state", state_dbg, 0);
        check("rst_rom_addr", gif.rom_addr, 0);
        check("rst_pix_color", gif.pix_color, 0);
        check("rst_pix_on", gif.pix_on, 0);
        check("rst_pix_last", gif.pix_last, 0);
        gif.char_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        check("post_rst_no_accept", busy, 0);
        check("post_rst_state", state_dbg, 0);

        // table: steady ready, then random backpressure
        foreach (vecs[i]) run_glyph(vecs[i], 1'b0);
        foreach (vecs[i]) run_glyph(vecs[i], 1'b1);

        // linear wiring: row1,col0 bit lands at index 5
        lif.char_in = 7'h42; lif.fg_in = 24'hFFFFFF; lif.bg_in = 24'h0;
        lif.char_valid = 1'b1; lif.pix_ready = 1'b1;
        tick();
        lif.char_valid = 1'b0;
        tick();
        first_idx = -1; ones = 0; idx = 0; guard = 0;
        while (idx < NPIX && guard < 100) begin
            if (lif.pix_valid) begin
                if (lif.pix_on) begin
                    ones++;
                    if (first_idx < 0) first_idx = idx;
                end
                idx++;
            end
            tick();
            guard++;
        end
        check("linear_on_index", first_idx, 5);
        check("linear_on_count", ones, 1);
        check("linear_handshakes", idx, NPIX);
        lif.pix_ready = 1'b0;

        // back-to-back with char_valid held high
        gif.pix_ready = 1'b1;
        gif.char_in = 7'h48; gif.fg_in = 24'h111111; gif.bg_in = 24'h222222;
        gif.char_valid = 1'b1;
        guard = 0;
        while (!gif.char_ready && guard < 50) begin tick(); guard++; end
        t1 = cyc + 1;
        tick();
        check("b2b_rom_addr_first", gif.rom_addr, 7'h48);
        gif.char_in = 7'h49;
        guard = 0;
        while (!gif.char_ready && guard < 100) begin tick(); guard++; end
        t2 = cyc + 1;
        check("b2b_accept_gap", t2 - t1, 37);
        tick();
        gif.char_valid = 1'b0;
        check("b2b_state_fetch", state_dbg, 1);
        check("b2b_rom_addr_second", gif.rom_addr, 7'h49);
        n = 0; guard = 0;
        while (guard < 100) begin
            if (gif.pix_valid) begin
                n++;
                if (gif.pix_last) begin
                    tick();
                    break;
                end
            end
            tick();
            guard++;
        end
        check("b2b_second_pixels", n, NPIX);
        check("b2b_idle", state_dbg, 0);

        // reset after pixel 10 has been taken
        cur_char = 7'h41; cur_bm = vecs[0].bm;
        gif.char_in = 7'h41; gif.fg_in = 24'hFF0000; gif.bg_in = 24'h0;
        gif.char_valid = 1'b1; gif.pix_ready = 1'b1;
        tick();
        gif.char_valid = 1'b0;
        tick();
        n = 0; guard = 0;
        while (n < 10 && guard < 50) begin
            if (gif.pix_valid) n++;
            tick();
            guard++;
        end
        check("mid_pixels_taken", n, 10);
        check("mid_still_streaming", gif.pix_valid, 1);
        rst_n = 1'b0;
        tick();
        check("mid_rst_pix_valid", gif.pix_valid, 0);
        check("mid_rst_state", state_dbg, 0);
        check("mid_rst_char_ready", gif.char_ready, 1);
        check("mid_rst_busy", busy, 0);
        rst_n = 1'b1;
        gif.pix_ready = 1'b0;
        tick();
        run_glyph(vecs[0], 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
